// File: rtl/operator_writeback.sv
// Final operator-pipeline stage: registers each operator sample onto the writeback
// bus and mixes the carrier outputs of one full voice-operator frame into a sample.
package operator_writeback_pkg;
   localparam int VOICE_OPERATOR_ID_WIDTH = 8;
   typedef logic [VOICE_OPERATOR_ID_WIDTH-1:0] VoiceOperatorID_t;
   typedef struct packed {
      logic [2:0] Algorithm;
      logic [2:0] OperatorIndex;
      logic       IsCarrier;
      logic       Feedback;
   } AlgorithmWord_t;
endpackage

module operator_writeback
   import operator_writeback_pkg::*;
#(
   parameter int NUM_VOICE_OPERATORS = 192,
   parameter int ACC_WIDTH           = 24,
   parameter int MIX_SHIFT           = 4
) (
   input  logic                    i_Clock,
   input  logic                    i_Reset,
   input  logic                    i_Valid,
   input  VoiceOperatorID_t        i_VoiceOperator,
   input  AlgorithmWord_t          i_AlgorithmWord,
   input  logic signed [15:0]      i_OperatorOutput,
   output logic                    o_OperatorWritebackValid,
   output VoiceOperatorID_t        o_OperatorWritebackID,
   output logic signed [15:0]      o_OperatorWritebackValue,
   output logic signed [15:0]      o_Sample,
   output logic                    o_SampleValid,
   output logic                    o_FrameOverflow
);

   localparam int IDW = VOICE_OPERATOR_ID_WIDTH;
   localparam VoiceOperatorID_t FIRST_ID = IDW'(0);
   localparam VoiceOperatorID_t LAST_ID  = IDW'(NUM_VOICE_OPERATORS - 1);
   localparam logic [0:0] ST_SYNC = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32'sd32767);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-32'sd32768);

   logic [0:0]                   state_q, state_d;
   VoiceOperatorID_t             prev_id_q, prev_id_d;
   logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic signed [ACC_WIDTH-1:0]  result_q, result_d;
   logic                         close_q, close_d;
   logic                         wb_valid_q, wb_valid_d;
   VoiceOperatorID_t             wb_id_q, wb_id_d;
   logic signed [15:0]           wb_value_q, wb_value_d;
   logic signed [15:0]           sample_q, sample_d;
   logic                         sample_valid_q, sample_valid_d;
   logic                         overflow_q, overflow_d;

   logic signed [ACC_WIDTH-1:0]  contrib_s;
   logic signed [ACC_WIDTH-1:0]  sum_s;
   logic signed [ACC_WIDTH-1:0]  shifted_s;
   logic signed [15:0]           sat_value_s;
   logic                         sat_hit_s;
   logic                         seq_ok_s;
   logic                         unused_algo_s;

   assign unused_algo_s = ^{i_AlgorithmWord.Algorithm, i_AlgorithmWord.OperatorIndex,
                            i_AlgorithmWord.Feedback};

   assign sum_s     = acc_q + contrib_s;
   assign shifted_s = result_q >>> MIX_SHIFT;
   // The wrap LAST_ID -> 0 is not a continuation; ID 0 always restarts a frame instead.
   assign seq_ok_s  = (state_q == ST_RUN) && (prev_id_q != LAST_ID) &&
                      (i_VoiceOperator == prev_id_q + IDW'(1));

   always_comb begin
      if (i_AlgorithmWord.IsCarrier) begin
         contrib_s = ACC_WIDTH'(i_OperatorOutput);
      end else begin
         contrib_s = '0;
      end
   end

   always_comb begin
      wb_valid_d = i_Valid;
      if (i_Valid) begin
         wb_id_d    = i_VoiceOperator;
         wb_value_d = i_OperatorOutput;
      end else begin
         wb_id_d    = wb_id_q;
         wb_value_d = wb_value_q;
      end
   end

   // Frame tracking: result_d only moves on a close, so a new frame may start next cycle.
   always_comb begin
      state_d   = state_q;
      prev_id_d = prev_id_q;
      acc_d     = acc_q;
      result_d  = result_q;
      close_d   = 1'b0;
      if (i_Valid) begin
         if (i_VoiceOperator == FIRST_ID) begin
            state_d   = ST_RUN;
            prev_id_d = i_VoiceOperator;
            acc_d     = contrib_s;
         end else if (seq_ok_s) begin
            prev_id_d = i_VoiceOperator;
            acc_d     = sum_s;
            if (i_VoiceOperator == LAST_ID) begin
               result_d = sum_s;
               close_d  = 1'b1;
            end else begin
               close_d  = 1'b0;
            end
         end else begin
            state_d = ST_SYNC;
         end
      end else begin
         state_d = state_q;
      end
   end

   always_comb begin
      sat_hit_s   = 1'b0;
      sat_value_s = shifted_s[15:0];
      if (shifted_s > SAT_MAX) begin
         sat_hit_s   = 1'b1;
         sat_value_s = 16'sh7FFF;
      end else if (shifted_s < SAT_MIN) begin
         sat_hit_s   = 1'b1;
         sat_value_s = -16'sh8000;
      end else begin
         sat_hit_s   = 1'b0;
      end
   end

   always_comb begin
      sample_valid_d = close_q;
      if (close_q) begin
         sample_d   = sat_value_s;
         overflow_d = overflow_q | sat_hit_s;
      end else begin
         sample_d   = sample_q;
         overflow_d = overflow_q;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q        <= ST_SYNC;
         prev_id_q      <= '0;
         acc_q          <= '0;
         result_q       <= '0;
         close_q        <= 1'b0;
         wb_valid_q     <= 1'b0;
         wb_id_q        <= '0;
         wb_value_q     <= '0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         prev_id_q      <= prev_id_d;
         acc_q          <= acc_d;
         result_q       <= result_d;
         close_q        <= close_d;
         wb_valid_q     <= wb_valid_d;
         wb_id_q        <= wb_id_d;
         wb_value_q     <= wb_value_d;
         sample_q       <= sample_d;
         sample_valid_q <= sample_valid_d;
         overflow_q     <= overflow_d;
      end
   end

   assign o_OperatorWritebackValid = wb_valid_q;
   assign o_OperatorWritebackID    = wb_id_q;
   assign o_OperatorWritebackValue = wb_value_q;
   assign o_Sample                 = sample_q;
   assign o_SampleValid            = sample_valid_q;
   assign o_FrameOverflow          = overflow_q;

endmodule
